// File: rtl/delay_pkg.sv
// Shared helpers for the delay-line family: delay-port width and depth clamping.
package delay_pkg;

  function automatic int calc_dw(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // A zero request still needs one register stage; oversize requests saturate.
  function automatic int clamp_depth(input int req, input int max_depth);
    if (req < 1) return 1;
    if (req > max_depth) return max_depth;
    return req;
  endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// DEPTH:1 selector returning the {data, valid} pair of the chosen stage.
module delay_tap_mux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SW    = 5
) (
  input  logic [DEPTH*WIDTH-1:0] i_data,
  input  logic [DEPTH-1:0]       i_vld,
  input  logic [SW-1:0]          i_sel,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_vld
);

  always_comb begin
    o_data = '0;
    o_vld  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_sel == SW'(k)) begin
        o_data = i_data[k*WIDTH +: WIDTH];
        o_vld  = i_vld[k];
      end
    end
  end

endmodule

// File: rtl/prog_delay_line.sv
// Programmable-depth delay line with stall, flush and a registered fill count.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_DEPTH     = 16,
  parameter int DEFAULT_DEPTH = 4,
  localparam int DW           = calc_dw(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [DW-1:0]    cfg_dly,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DW-1:0]    dly_cur,
  output logic [DW-1:0]    fill
);

  logic [MAX_DEPTH*WIDTH-1:0] r_data;
  logic [MAX_DEPTH-1:0]       r_vld;
  logic [DW-1:0]              r_dly;
  logic [DW-1:0]              r_fill;

  logic [MAX_DEPTH-1:0]       w_vld_nxt;
  logic [DW-1:0]              w_dly_nxt;
  logic [DW-1:0]              w_fill_nxt;
  logic [DW-1:0]              w_sel;
  logic                       w_clr;

  assign w_clr     = flush | cfg_we;
  assign w_dly_nxt = cfg_we ? DW'(clamp_depth(int'(cfg_dly), MAX_DEPTH)) : r_dly;

  // Clearing wins over a coincident shift, so an entering valid is dropped too.
  always_comb begin
    w_vld_nxt = r_vld;
    if (en) begin
      w_vld_nxt[0] = din_valid;
      for (int k = 1; k < MAX_DEPTH; k++) w_vld_nxt[k] = r_vld[k-1];
    end
    if (w_clr) w_vld_nxt = '0;
  end

  // Fill is computed from next-state valids and depth so the register matches after every edge.
  always_comb begin
    w_fill_nxt = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (w_vld_nxt[k] && (k < int'(w_dly_nxt))) w_fill_nxt = w_fill_nxt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (en) begin
      r_data[WIDTH-1:0] <= din;
      for (int k = 1; k < MAX_DEPTH; k++)
        r_data[k*WIDTH +: WIDTH] <= r_data[(k-1)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_dly  <= DW'(DEFAULT_DEPTH);
      r_fill <= '0;
    end else begin
      r_vld  <= w_vld_nxt;
      r_dly  <= w_dly_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  assign w_sel = r_dly - DW'(1);

  delay_tap_mux #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .SW    (DW)
  ) u_tap (
    .i_data (r_data),
    .i_vld  (r_vld),
    .i_sel  (w_sel),
    .o_data (dout),
    .o_vld  (dout_valid)
  );

  assign dly_cur = r_dly;
  assign fill    = r_fill;

endmodule

// File: tb/tb_prog_delay_line.sv
// Randomized bench for prog_delay_line against a history-based reference model.
module tb_prog_delay_line;
  localparam int WIDTH = 8;
  localparam int MAXD  = 16;
  localparam int DEFD  = 4;
  localparam int DW    = $clog2(MAXD + 1);
  localparam int HMAX  = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             flush;
  logic             cfg_we;
  logic [DW-1:0]    cfg_dly;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [DW-1:0]    dly_cur;
  logic [DW-1:0]    fill;

  int total = 0;
  int bad   = 0;

  // Model: every enabled edge n records (din, din_valid); stage k holds edge E-k.
  // A clear marks all edges up to the current one as invalid.
  logic [WIDTH-1:0] hd [HMAX];
  bit               hv [HMAX];
  int               E, mark, mdly;

  always #5 clk = ~clk;

  prog_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DEFAULT_DEPTH(DEFD)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .flush(flush), .cfg_we(cfg_we), .cfg_dly(cfg_dly),
    .dout(dout), .dout_valid(dout_valid), .dly_cur(dly_cur), .fill(fill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    E = 0; mark = 0; mdly = DEFD;
  endtask

  function automatic logic [WIDTH-1:0] exp_data(input int k);
    int idx = E - k;
    return (idx >= 1) ? hd[idx] : '0;
  endfunction

  function automatic bit exp_vld(input int k);
    int idx = E - k;
    return (idx >= 1) && (idx > mark) && hv[idx];
  endfunction

  function automatic int exp_fill();
    int c = 0;
    for (int k = 0; k < mdly; k++) if (exp_vld(k)) c++;
    return c;
  endfunction

  task automatic check_outputs();
    check("dout_valid", 32'(dout_valid), 32'(exp_vld(mdly - 1)));
    check("dout",       32'(dout),       32'(exp_data(mdly - 1)));
    check("dly_cur",    32'(dly_cur),    32'(mdly));
    check("fill",       32'(fill),       32'(exp_fill()));
  endtask

  task automatic step(input bit e, input bit dv, input logic [WIDTH-1:0] d,
                      input bit fl, input bit we, input logic [DW-1:0] cd);
    en = e; din_valid = dv; din = d; flush = fl; cfg_we = we; cfg_dly = cd;
    @(posedge clk);
    if (e && E < HMAX - 1) begin
      E++;
      hd[E] = d;
      hv[E] = dv;
    end
    if (fl || we) mark = E;
    if (we) mdly = (cd == 0) ? 1 : ((int'(cd) > MAXD) ? MAXD : int'(cd));
    @(negedge clk);
    flush = 1'b0; cfg_we = 1'b0;
    check_outputs();
  endtask

  task automatic rand_step();
    bit e  = ($urandom_range(0, 3) != 0);
    bit dv = ($urandom_range(0, 3) != 0);
    bit fl = ($urandom_range(0, 29) == 0);
    bit we = ($urandom_range(0, 29) == 0);
    step(e, dv, WIDTH'($urandom), fl, we, DW'($urandom_range(0, 31)));
  endtask

  logic [WIDTH-1:0] held;

  initial begin
    rst = 1'b1; en = 0; din = '0; din_valid = 0; flush = 0; cfg_we = 0; cfg_dly = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_dout",   32'(dout),       0);
    check("rst_dvalid", 32'(dout_valid), 0);
    check("rst_dly",    32'(dly_cur),    DEFD);
    check("rst_fill",   32'(fill),       0);
    rst = 1'b0;

    // Contiguous stream at default depth.
    for (int i = 1; i <= 12; i++) begin
      step(1, 1, WIDTH'(i), 0, 0, '0);
      if (i == 3) check("first_not_yet", 32'(dout_valid), 0);
      if (i == 4) begin
        check("first_valid", 32'(dout_valid), 1);
        check("first_data",  32'(dout),       1);
      end
    end

    // Stall: output and fill frozen.
    held = dout;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, WIDTH'($urandom), 0, 0, '0);
      check("stall_dout", 32'(dout), 32'(held));
      check("stall_fill", 32'(fill), 4);
    end
    for (int i = 13; i <= 18; i++) step(1, 1, WIDTH'(i), 0, 0, '0);
    check("resume_data", 32'(dout), 15);

    // Depth clamping.
    step(0, 0, '0, 0, 1, DW'(0));
    check("clamp_lo", 32'(dly_cur), 1);
    check("clamp_lo_fill", 32'(fill), 0);
    step(1, 1, 8'h77, 0, 1, DW'(MAXD + 5));
    check("clamp_hi", 32'(dly_cur), MAXD);
    check("clamp_hi_vld", 32'(dout_valid), 0);

    // Depth change 4 -> 8 mid-stream.
    step(0, 0, '0, 0, 1, DW'(4));
    for (int i = 0; i < 6; i++) step(1, 1, WIDTH'(8'h20 + i), 0, 0, '0);
    step(1, 1, 8'h55, 0, 1, DW'(8));
    for (int i = 0; i < 12; i++) begin
      step(1, 1, WIDTH'(8'h30 + i), 0, 0, '0);
      if (i < 7) check("dchg_gap", 32'(dout_valid), 0);
      if (i == 7) begin
        check("dchg_first_vld",  32'(dout_valid), 1);
        check("dchg_first_data", 32'(dout),       32'h30);
      end
    end

    // Flush coinciding with a valid input.
    for (int i = 0; i < 4; i++) step(1, 1, WIDTH'(8'h40 + i), 0, 0, '0);
    step(1, 1, 8'hAA, 1, 0, '0);
    check("flush_fill", 32'(fill), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, WIDTH'(8'h60 + i), 0, 0, '0);
      check("flush_aa", 32'(dout_valid && dout == 8'hAA), 0);
    end

    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset between edges with the line full.
    step(1, 1, 8'h01, 0, 1, DW'(6));
    for (int i = 0; i < 8; i++) step(1, 1, WIDTH'(8'h90 + i), 0, 0, '0);
    check("pre_rst_vld", 32'(dout_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_dout",   32'(dout),       0);
    check("arst_dvalid", 32'(dout_valid), 0);
    check("arst_dly",    32'(dly_cur),    DEFD);
    check("arst_fill",   32'(fill),       0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    for (int i = 0; i < 60; i++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_delay_line.md
PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data bits per sample.
REQ-002 The module SHALL have parameter MAX_DEPTH, default 16, meaning the maximum delay in enabled cycles (>=1).
REQ-003 The module SHALL have parameter DEFAULT_DEPTH, default 4, meaning the delay after reset (1..MAX_DEPTH).
REQ-004 The module SHALL derive DW = clog2(MAX_DEPTH+1) as the width of every delay-value port.
REQ-005 The module SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst, input, width 1, asynchronous active-high reset.
REQ-007 The module SHALL have port en, input, width 1, advance enable; 0 stalls the line.
REQ-008 The module SHALL have port din, input, width WIDTH, the input sample.
REQ-009 The module SHALL have port din_valid, input, width 1, qualifying din.
REQ-010 The module SHALL have port flush, input, width 1, which clears all valid flags.
REQ-011 The module SHALL have port cfg_we, input, width 1, a one-cycle strobe that loads cfg_dly.
REQ-012 The module SHALL have port cfg_dly, input, width DW, the requested delay.
REQ-013 The module SHALL have port dout, output, width WIDTH, the delayed sample.
REQ-014 The module SHALL have port dout_valid, output, width 1, qualifying dout.
REQ-015 The module SHALL have port dly_cur, output, width DW, the active delay.
REQ-016 The module SHALL have port fill, output, width DW, the count of valid entries in stages 0..dly_cur-1.

Function
REQ-017 The line SHALL be MAX_DEPTH stages, each holding {data, valid}; stage 0 is the input stage.
REQ-018 On an edge with en=1, stage0 SHALL load {din, din_valid} and stage k SHALL load stage k-1 for all k>=1.
REQ-019 On an edge with en=0, all stages SHALL hold, so stall has no effect on ordering or loss.
REQ-020 dout and dout_valid SHALL equal stage[dly_cur-1] combinationally, with no added register.
REQ-021 A sample accepted at an enabled edge SHALL appear at dout after exactly dly_cur enabled edges; disabled edges do not count.
REQ-022 On cfg_we, dly_cur SHALL load the clamped cfg_dly: 0 loads 1, values above MAX_DEPTH load MAX_DEPTH.
REQ-023 cfg_we SHALL act regardless of en.
REQ-024 On cfg_we, all valid flags SHALL clear, so no sample is duplicated or dropped in a misordered way across a depth change.
REQ-025 flush SHALL clear all valid flags regardless of en.
REQ-026 Data bits SHALL be left unchanged by cfg_we and flush; only valid flags clear.
REQ-027 When flush or cfg_we coincides with en=1, clearing SHALL take priority, and stage0 valid becomes 0 even if din_valid=1.
REQ-028 Simultaneous flush and cfg_we SHALL both take effect.
REQ-029 fill SHALL be registered and consistent with the stage valids after each edge, and SHALL be 0 after a flush or cfg_we edge.
REQ-030 fill SHALL never exceed dly_cur.

Reset
REQ-031 While rst=1, asynchronously: all stage data SHALL be 0, all valid flags 0, dly_cur = DEFAULT_DEPTH, fill = 0, dout = 0, dout_valid = 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight samples.
REQ-033 The first edge after rst deasserts SHALL behave as a normal edge.

Structure
REQ-034 Package delay_pkg SHALL hold the DW computation function and the depth-clamp function, shared with future delay blocks.
REQ-035 Sub-module delay_tap_mux SHALL implement the MAX_DEPTH:1 {data, valid} selector indexed by dly_cur-1.
REQ-036 The stage array, the enable/clear logic, dly_cur and the fill counter SHALL remain in the top module.

Verification
REQ-037 Reset, then en=1 and din_valid=1 with din=0x01,0x02,... -> dout_valid first rises on the 4th edge with dout=0x01, and the sequence continues contiguously.
REQ-038 With DEFAULT_DEPTH=4 and a stream running, hold en=0 for 3 cycles -> dout is frozen for those cycles, fill stays 4, and no sample is lost after resume.
REQ-039 cfg_we with cfg_dly=0 -> dly_cur=1; cfg_we with cfg_dly=MAX_DEPTH+5 (if representable in DW) -> dly_cur=MAX_DEPTH, otherwise cfg_dly=MAX_DEPTH -> dly_cur=MAX_DEPTH; each write leaves dout_valid=0 and fill=0 on the next cycle.
REQ-040 Change depth 4->8 mid-stream -> dout_valid is 0 for 8 enabled cycles, then the first output is the first sample accepted after the change.
REQ-041 Assert flush together with en=1 and din_valid=1 (din=0xAA) -> 0xAA never appears valid at dout, and fill=0.
REQ-042 Assert rst asynchronously between edges with the line full -> dout=0 and dout_valid=0 immediately, and dly_cur=DEFAULT_DEPTH.
